// File: rtl/gpio_in_capture.sv
// GPIO input capture: per-pin synchronizer, debounce, sticky edge status (W1C), mask and level IRQ.
// Build option GPIO_FALL_EDGE_EN adds the EDGESEL register (addr 3) for per-pin falling-edge capture.
module gpio_in_capture #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  gpio_port_in,
  input  logic [1:0]        gpio_addr,
  input  logic              gpio_wren,
  input  logic [31:0]       gpio_wrdata,
  output logic [31:0]       gpio_rddata,
  output logic              gpio_irq
);

  localparam int unsigned     CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      ADDR_LEVEL   = 2'd0;
  localparam logic [1:0]      ADDR_STATUS  = 2'd1;
  localparam logic [1:0]      ADDR_MASK    = 2'd2;
  localparam logic [1:0]      ADDR_EDGESEL = 2'd3;

  logic [WIDTH-1:0] sync_q   [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d   [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q    [WIDTH];
  logic [CNT_W-1:0] cnt_d    [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] mask_q,   mask_d;
  logic [WIDTH-1:0] synced_c;
  logic [WIDTH-1:0] toggled_c;
  logic [WIDTH-1:0] event_c;
  logic [WIDTH-1:0] wr_bits_c;
  logic [WIDTH-1:0] edgesel_c;
  logic [31:0]      rddata_d;
  logic             irq_d;
  logic             unused_wrdata;

`ifdef GPIO_FALL_EDGE_EN
  logic [WIDTH-1:0] edgesel_q, edgesel_d;
`endif

  // Only the low WIDTH bits of write data carry meaning.
  assign unused_wrdata = ^gpio_wrdata;
  assign wr_bits_c     = gpio_wrdata[WIDTH-1:0];
  assign synced_c      = sync_q[SYNC_STAGES-1];

`ifdef GPIO_FALL_EDGE_EN
  assign edgesel_c = edgesel_q;
`else
  assign edgesel_c = '0;
`endif

  // Next-state logic for synchronizer, debounce, status, mask and read/irq outputs.
  always_comb begin
    sync_d[0] = gpio_port_in;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end

    stable_d = stable_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (synced_c[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = synced_c[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // An edge counts when the new level matches the selected polarity (0 = rising, 1 = falling).
    toggled_c = stable_d ^ stable_q;
    event_c   = toggled_c & (stable_d ^ edgesel_c);

    status_d = status_q;
    if (gpio_wren && (gpio_addr == ADDR_STATUS)) begin
      status_d = status_q & ~wr_bits_c;
    end
    status_d = status_d | event_c;

    mask_d = mask_q;
    if (gpio_wren && (gpio_addr == ADDR_MASK)) begin
      mask_d = wr_bits_c;
    end

`ifdef GPIO_FALL_EDGE_EN
    edgesel_d = edgesel_q;
    if (gpio_wren && (gpio_addr == ADDR_EDGESEL)) begin
      edgesel_d = wr_bits_c;
    end
`endif

    rddata_d = '0;
    case (gpio_addr)
      ADDR_LEVEL:   rddata_d = 32'(stable_q);
      ADDR_STATUS:  rddata_d = 32'(status_q);
      ADDR_MASK:    rddata_d = 32'(mask_q);
      ADDR_EDGESEL: rddata_d = 32'(edgesel_c);
      default:      rddata_d = '0;
    endcase

    irq_d = |(status_q & mask_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q    <= '0;
      status_q    <= '0;
      mask_q      <= '0;
`ifdef GPIO_FALL_EDGE_EN
      edgesel_q   <= '0;
`endif
      gpio_rddata <= '0;
      gpio_irq    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q    <= stable_d;
      status_q    <= status_d;
      mask_q      <= mask_d;
`ifdef GPIO_FALL_EDGE_EN
      edgesel_q   <= edgesel_d;
`endif
      gpio_rddata <= rddata_d;
      gpio_irq    <= irq_d;
    end
  end

endmodule

// File: tb/tb_gpio_in_capture.sv
// Randomized bench for gpio_in_capture with a window-based reference model and directed literal checks.
module tb_gpio_in_capture;

  localparam int WIDTH           = 8;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pins;
  logic [1:0]  addr;
  logic        wren;
  logic [31:0] wrdata;
  logic [31:0] rddata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpio_in_capture #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gpio_port_in(pins),
    .gpio_addr(addr),
    .gpio_wren(wren),
    .gpio_wrdata(wrdata),
    .gpio_rddata(rddata),
    .gpio_irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: pin history per edge; a level is accepted once the last
  // DEBOUNCE_CYCLES synchronized samples all disagree with it and no earlier
  // acceptance or reset falls inside that window.
  logic [7:0]  hist[$];
  int          n        = 0;
  int          last_rst = 0;
  int          last_evt [8];
  logic [7:0]  m_stable  = '0;
  logic [7:0]  m_status  = '0;
  logic [7:0]  m_mask    = '0;
  logic [7:0]  m_edgesel = '0;
  logic [31:0] exp_rd    = '0;
  logic        exp_irq   = 1'b0;
  bit          model_on  = 1'b0;

  function automatic logic [7:0] synced_at(input int k);
    if (k - SYNC_STAGES <= last_rst) return 8'h00;
    return hist[k - SYNC_STAGES];
  endfunction

  always @(posedge clk) begin : model
    logic [7:0] ev;
    logic [7:0] nst;
    logic [7:0] s;
    bit         diff;
    hist.push_back(rst ? pins : 8'h00);
    if (!rst) begin
      last_rst = n;
      for (int i = 0; i < 8; i++) last_evt[i] = n;
      m_stable  = '0;
      m_status  = '0;
      m_mask    = '0;
      m_edgesel = '0;
      exp_rd    = '0;
      exp_irq   = 1'b0;
    end else begin
      case (addr)
        2'd0:    exp_rd = {24'h0, m_stable};
        2'd1:    exp_rd = {24'h0, m_status};
        2'd2:    exp_rd = {24'h0, m_mask};
        default: exp_rd = {24'h0, m_edgesel};
      endcase
      exp_irq = |(m_status & m_mask);
      ev  = '0;
      nst = m_stable;
      for (int i = 0; i < 8; i++) begin
        if (n - last_evt[i] >= DEBOUNCE_CYCLES) begin
          diff = 1'b1;
          for (int j = 0; j < DEBOUNCE_CYCLES; j++) begin
            s = synced_at(n - j);
            if (s[i] == m_stable[i]) diff = 1'b0;
          end
          if (diff) begin
            nst[i]      = ~m_stable[i];
            last_evt[i] = n;
`ifdef GPIO_FALL_EDGE_EN
            if (nst[i] != m_edgesel[i]) ev[i] = 1'b1;
`else
            if (nst[i]) ev[i] = 1'b1;
`endif
          end
        end
      end
      if (wren && addr == 2'd1) m_status = (m_status & ~wrdata[7:0]) | ev;
      else                      m_status = m_status | ev;
      if (wren && addr == 2'd2) m_mask = wrdata[7:0];
`ifdef GPIO_FALL_EDGE_EN
      if (wren && addr == 2'd3) m_edgesel = wrdata[7:0];
`endif
      m_stable = nst;
    end
    model_on = 1'b1;
    n++;
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if (rddata !== exp_rd) begin
        errors++;
        $display("FAIL rddata cycle %0d: got 0x%08h expected 0x%08h", n, rddata, exp_rd);
      end
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("FAIL irq cycle %0d: got %b expected %b", n, irq, exp_irq);
      end
    end
  end

  task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wren   = 1'b1;
    addr   = a;
    wrdata = d;
    step(1);
    wren   = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    pins   = 8'hFF;
    addr   = 2'd0;
    wren   = 1'b0;
    wrdata = '0;

    // Reset with pins high, then release.
    step(1);
    expect_lit("reset_rd_0", rddata, 32'h0);
    expect_lit("reset_irq_0", 32'(irq), 32'h0);
    step(1);
    expect_lit("reset_rd_1", rddata, 32'h0);
    rst = 1'b1;
    step(6);
    expect_lit("level_before_release_latency", rddata, 32'h0);
    step(1);
    expect_lit("level_after_release_latency", rddata, 32'hFF);

    // Single rising pin with mask enabled.
    pins = 8'h00;
    step(12);
    wr(2'd1, 32'hFF);
    wr(2'd2, 32'h01);
    addr = 2'd1;
    pins = 8'h01;
    step(6);
    expect_lit("status_before_latency", rddata, 32'h0);
    expect_lit("irq_before_latency", 32'(irq), 32'h0);
    step(1);
    expect_lit("status_bit0_set", rddata, 32'h01);
    expect_lit("irq_bit0_set", 32'(irq), 32'h1);

    // W1C clears status and irq.
    wr(2'd1, 32'h01);
    step(1);
    expect_lit("status_w1c", rddata, 32'h0);
    expect_lit("irq_w1c", 32'(irq), 32'h0);

    // Short pulse on bit1 is rejected.
    pins = 8'h03;
    step(3);
    pins = 8'h01;
    step(12);
    expect_lit("glitch_status", rddata, 32'h0);
    expect_lit("glitch_irq", 32'(irq), 32'h0);
    addr = 2'd0;
    step(1);
    expect_lit("glitch_level", rddata, 32'h01);

    // Event and W1C on the same bit in the same cycle: set wins.
    pins = 8'h00;
    step(12);
    addr = 2'd1;
    pins = 8'h01;
    step(5);
    wr(2'd1, 32'h01);
    step(1);
    expect_lit("set_wins_status", rddata, 32'h01);
    expect_lit("set_wins_irq", 32'(irq), 32'h1);

    // Edge select on bit2.
    wr(2'd1, 32'hFF);
    wr(2'd3, 32'h04);
    addr = 2'd1;
    pins = 8'h05;
    step(8);
`ifdef GPIO_FALL_EDGE_EN
    expect_lit("edgesel_after_rise", rddata, 32'h00);
`else
    expect_lit("edgesel_after_rise", rddata, 32'h04);
`endif
    pins = 8'h01;
    step(8);
    expect_lit("edgesel_after_fall", rddata, 32'h04);
    addr = 2'd3;
    step(1);
`ifdef GPIO_FALL_EDGE_EN
    expect_lit("edgesel_read", rddata, 32'h04);
`else
    expect_lit("edgesel_read", rddata, 32'h00);
`endif

    // Reset mid-debounce discards partial counts.
    pins = 8'h00;
    step(12);
    wr(2'd1, 32'hFF);
    addr = 2'd0;
    pins = 8'h08;
    step(3);
    rst = 1'b0;
    step(1);
    expect_lit("mid_reset_rd", rddata, 32'h0);
    expect_lit("mid_reset_irq", 32'(irq), 32'h0);
    rst = 1'b1;
    step(6);
    expect_lit("mid_reset_level_early", rddata, 32'h0);
    step(1);
    expect_lit("mid_reset_level", rddata, 32'h08);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) pins[b] = ~pins[b];
      end
      addr = 2'($urandom_range(0, 3));
      wren = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        wren   = 1'b1;
        wrdata = $urandom;
      end
      rst = ($urandom_range(0, 499) != 0);
      step(1);
    end
    rst  = 1'b1;
    wren = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
